// File: rtl/board_line_clear.sv
// Playfield store for a falling-block game: merges a locked piece into the grid,
// clears full rows bottom-up with gravity shift, and accumulates a saturating score.
module board_line_clear #(
  parameter int unsigned SCORE_MAX = 1023
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       board_clear,
  input  logic       lock_valid,
  output logic       lock_ready,
  input  logic [3:0] cell_x     [4],
  input  logic [4:0] cell_y     [4],
  input  logic [2:0] cell_color,
  output logic [2:0] grid       [20][10],
  output logic [9:0] score,
  output logic       clear_done,
  output logic       game_over
);

  localparam int unsigned Rows    = 20;
  localparam int unsigned Cols    = 10;
  localparam logic [4:0]  LastRow = 5'd19;

  typedef enum logic [2:0] {
    StIdle,
    StMerge,
    StScan,
    StShift,
    StDone
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  grid_q  [Rows][Cols];
  logic [2:0]  grid_d  [Rows][Cols];
  logic [9:0]  score_q, score_d;
  logic [4:0]  row_q, row_d;
  logic [2:0]  lines_q, lines_d;
  logic        go_q, go_d;
  logic [3:0]  cap_x_q [4];
  logic [3:0]  cap_x_d [4];
  logic [4:0]  cap_y_q [4];
  logic [4:0]  cap_y_d [4];
  logic [2:0]  cap_c_q, cap_c_d;

  logic [Rows-1:0] row_full;
  logic            cur_full;
  logic [Cols-1:0] hit [Rows];
  logic            piece_bad;
  logic [3:0]      points;
  logic [10:0]     score_sum;
  logic [9:0]      score_sat;

  always_comb begin
    row_full = '0;
    for (int r = 0; r < Rows; r++) begin
      row_full[r] = 1'b1;
      for (int c = 0; c < Cols; c++) begin
        if (grid_q[r][c] == 3'd0) begin
          row_full[r] = 1'b0;
        end
      end
    end
  end

  always_comb begin
    cur_full = 1'b0;
    for (int r = 0; r < Rows; r++) begin
      if (row_q == 5'(r)) begin
        cur_full = row_full[r];
      end
    end
  end

  // Cell-by-cell match keeps every index in range even for bad coordinates,
  // and makes duplicate coordinates collapse onto a single write.
  always_comb begin
    piece_bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (cap_x_q[i] > 4'd9 || cap_y_q[i] > 5'd19) begin
        piece_bad = 1'b1;
      end
    end
    for (int r = 0; r < Rows; r++) begin
      hit[r] = '0;
      for (int c = 0; c < Cols; c++) begin
        for (int i = 0; i < 4; i++) begin
          if (cap_y_q[i] == 5'(r) && cap_x_q[i] == 4'(c)) begin
            hit[r][c] = 1'b1;
          end
        end
        if (hit[r][c] && grid_q[r][c] != 3'd0) begin
          piece_bad = 1'b1;
        end
      end
    end
  end

  always_comb begin
    points = 4'd0;
    case (lines_q)
      3'd1:    points = 4'd1;
      3'd2:    points = 4'd3;
      3'd3:    points = 4'd5;
      3'd4:    points = 4'd8;
      default: points = 4'd0;
    endcase
    score_sum = {1'b0, score_q} + 11'(points);
    score_sat = (score_sum > 11'(SCORE_MAX)) ? 10'(SCORE_MAX) : score_sum[9:0];
  end

  always_comb begin
    state_d = state_q;
    grid_d  = grid_q;
    score_d = score_q;
    row_d   = row_q;
    lines_d = lines_q;
    go_d    = go_q;
    cap_x_d = cap_x_q;
    cap_y_d = cap_y_q;
    cap_c_d = cap_c_q;
    case (state_q)
      StIdle: begin
        if (board_clear) begin
          grid_d  = '{default: '{default: 3'd0}};
          score_d = '0;
        end else if (lock_valid && !go_q) begin
          cap_x_d = cell_x;
          cap_y_d = cell_y;
          cap_c_d = cell_color;
          state_d = StMerge;
        end
      end
      StMerge: begin
        if (piece_bad) begin
          go_d    = 1'b1;
          state_d = StDone;
        end else begin
          for (int r = 0; r < Rows; r++) begin
            for (int c = 0; c < Cols; c++) begin
              if (hit[r][c]) begin
                grid_d[r][c] = cap_c_q;
              end
            end
          end
          row_d   = LastRow;
          state_d = StScan;
        end
      end
      StScan: begin
        if (cur_full) begin
          state_d = StShift;
        end else if (row_q == 5'd0) begin
          state_d = StDone;
        end else begin
          row_d = row_q - 5'd1;
        end
      end
      StShift: begin
        for (int r = 1; r < Rows; r++) begin
          if (5'(r) <= row_q) begin
            grid_d[r] = grid_q[r-1];
          end
        end
        grid_d[0] = '{default: 3'd0};
        lines_d   = lines_q + 3'd1;
        state_d   = StScan;
      end
      StDone: begin
        score_d = score_sat;
        lines_d = '0;
        row_d   = LastRow;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      grid_q  <= '{default: '{default: 3'd0}};
      score_q <= '0;
      row_q   <= LastRow;
      lines_q <= '0;
      go_q    <= 1'b0;
      cap_x_q <= '{default: 4'd0};
      cap_y_q <= '{default: 5'd0};
      cap_c_q <= '0;
    end else begin
      state_q <= state_d;
      grid_q  <= grid_d;
      score_q <= score_d;
      row_q   <= row_d;
      lines_q <= lines_d;
      go_q    <= go_d;
      cap_x_q <= cap_x_d;
      cap_y_q <= cap_y_d;
      cap_c_q <= cap_c_d;
    end
  end

  assign lock_ready = (state_q == StIdle) && !go_q;
  assign clear_done = (state_q == StDone);
  assign game_over  = go_q;
  assign score      = score_q;
  assign grid       = grid_q;

endmodule

// File: doc/board_line_clear.md
BOARD_LINE_CLEAR -- requirements
Module: board_line_clear

Interface
REQ-001 Parameter SCORE_MAX, default 1023: saturation ceiling of score.
REQ-002 Clk  in  1  sole clock; all state updates on rising edge.
REQ-003 Reset  in  1  asynchronous, active-high reset.
REQ-004 board_clear  in  1  request to empty board and zero score; honoured only in IDLE.
REQ-005 lock_valid  in  1  locked-piece merge request.
REQ-006 lock_ready  out  1  high only in IDLE with game_over=0.
REQ-007 cell_x[4]  in  4 each  column of each piece cell, 0..9 valid.
REQ-008 cell_y[4]  in  5 each  row of each piece cell, 0..19 valid, 0 = top row.
REQ-009 cell_color  in  3  palette index written to all four cells; 1..7 valid.
REQ-010 grid[20][10]  out  3 each  board contents, grid[row][col], 0 = empty; drives the colour mapper directly.
REQ-011 score  out  10  accumulated score.
REQ-012 clear_done  out  1  one-cycle pulse when a merge/clear sequence completes.
REQ-013 game_over  out  1  sticky flag; cleared only by Reset.

Function
REQ-014 FSM states SHALL be IDLE, MERGE, SCAN, SHIFT, DONE.
REQ-015 Handshake: lock_valid & lock_ready at edge t -> capture cell_x, cell_y, cell_color; state MERGE during cycle t+1; inputs ignored afterwards.
REQ-016 board_clear in IDLE (priority over lock_valid) -> all grid cells 0, score 0 at next edge; no clear_done pulse; ignored outside IDLE.
REQ-017 MERGE, 1 cycle: if any cell has x>9, y>19, or a nonzero target cell -> no cell written, game_over set, go DONE; else write cell_color to all four cells, row pointer r=19, go SCAN.
REQ-018 SCAN, 1 cycle per row: row r full (all 10 cells nonzero) -> go SHIFT; else r=0 -> go DONE; else r decrements and stay in SCAN.
REQ-019 SHIFT, 1 cycle: rows r..1 take contents of row above, row 0 all zero, line count +1, return to SCAN with r unchanged so shifted-in row is rechecked.
REQ-020 Line count SHALL be 3 bits, max 4 per sequence.
REQ-021 DONE, 1 cycle: score += 0/1/3/5/8 for 0/1/2/3/4 lines, saturating at SCORE_MAX; clear_done=1; line count 0; go IDLE.
REQ-022 Latency, no full rows: handshake at t -> SCAN t+2..t+21, DONE/clear_done at t+22, lock_ready high at t+23; each full row adds 2 cycles.
REQ-023 Latency, failed merge: DONE at t+2, clear_done at t+2, lock_ready stays 0 thereafter.
REQ-024 grid SHALL change only at MERGE, SHIFT and board_clear edges; stable during SCAN and DONE.
REQ-025 Duplicate cell coordinates within one piece SHALL write once, with no game_over.
REQ-026 Score arithmetic SHALL be 11-bit internal sum compared against SCORE_MAX; never wraps.

Reset
REQ-027 Reset asserted at any time, including mid-SCAN or mid-SHIFT, SHALL immediately force state IDLE, grid all 0, score 0, clear_done 0, game_over 0, line count 0, row pointer 19.
REQ-028 First edge after Reset deasserts SHALL see lock_ready=1.

Verification
REQ-029 Empty board, lock cells (0,19),(1,19),(2,19),(3,19), color 3 -> those cells =3, clear_done at t+22, score 0.
REQ-030 Row 19 holds cols 0..5 = 1; lock cols 6..9 at row 19, color 2 -> row 19 cleared, row above shifts down, score 1, clear_done at t+24.
REQ-031 Rows 16..19 each filled in cols 0..8; vertical I piece at col 9 rows 16..19 -> four lines, board empty, score 8, clear_done at t+30.
REQ-032 Lock onto an occupied cell, or cell_y=20 -> grid unchanged, game_over=1, clear_done at t+2, lock_ready held 0 for subsequent lock_valid.
REQ-033 score preloaded to 1020 via three-line clears, then a four-line clear -> score 1023 (saturated, no wrap).
REQ-034 Reset pulsed during SHIFT -> all outputs at reset values same cycle; next lock accepted normally.
